// File: rtl/eth_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eth_pkg                                                         |
// | Brief    : Shared types and header field widths for the Ethernet arbiter.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package eth_pkg;

   localparam int MAC_W  = 48;
   localparam int TYPE_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HDR     = 2'd1,
      ST_PAYLOAD = 2'd2
   } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/eth_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eth_rr_arbiter                                                  |
// | Brief    : Request arbiter; round-robin when ETH_FRAME_ARB_ROUND_ROBIN_EN  |
// |            is defined, otherwise fixed priority (lowest index wins).       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module eth_rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req_i,
   input  logic          upd_en_i,
   output logic          grant_any_o,
   output logic [N-1:0]  grant_oh_o,
   output logic [IW-1:0] grant_idx_o
);

   logic [IW-1:0] w_idx;

   assign grant_any_o = |req_i;
   assign grant_idx_o = w_idx;
   assign grant_oh_o  = grant_any_o ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;

`ifdef ETH_FRAME_ARB_ROUND_ROBIN_EN
   logic [IW-1:0] ptr_q;
   logic [IW-1:0] w_idx_lo;
   logic [IW-1:0] w_idx_hi;
   logic          w_hit_hi;

   // Lowest requester at or above the pointer wins; otherwise wrap to the lowest.
   always_comb begin
      w_idx_lo = '0;
      w_idx_hi = '0;
      w_hit_hi = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            w_idx_lo = IW'(i);
            if (IW'(i) >= ptr_q) begin
               w_idx_hi = IW'(i);
               w_hit_hi = 1'b1;
            end
         end
      end
      w_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (upd_en_i && grant_any_o) begin
         ptr_q <= (w_idx == IW'(N - 1)) ? '0 : w_idx + IW'(1);
      end
   end
`else
   logic w_unused;

   always_comb begin
      w_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            w_idx = IW'(i);
         end
      end
   end

   assign w_unused = ^{clk, rst, upd_en_i};
`endif

endmodule
`default_nettype wire

// File: rtl/eth_frame_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : eth_frame_arb                                                   |
// | Brief    : Merges S_COUNT Ethernet header+payload sources frame by frame.  |
// |            Define ETH_FRAME_ARB_ROUND_ROBIN_EN for round-robin arbitration.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module eth_frame_arb
   import eth_pkg::*;
#(
   parameter int S_COUNT    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [S_COUNT-1:0]            s_eth_hdr_valid,
   output logic [S_COUNT-1:0]            s_eth_hdr_ready,
   input  logic [S_COUNT*48-1:0]         s_eth_dest_mac,
   input  logic [S_COUNT*48-1:0]         s_eth_src_mac,
   input  logic [S_COUNT*16-1:0]         s_eth_type,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_eth_payload_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_eth_payload_axis_tvalid,
   output logic [S_COUNT-1:0]            s_eth_payload_axis_tready,
   input  logic [S_COUNT-1:0]            s_eth_payload_axis_tlast,
   input  logic [S_COUNT-1:0]            s_eth_payload_axis_tuser,
   output logic                          m_eth_hdr_valid,
   input  logic                          m_eth_hdr_ready,
   output logic [47:0]                   m_eth_dest_mac,
   output logic [47:0]                   m_eth_src_mac,
   output logic [15:0]                   m_eth_type,
   output logic [DATA_WIDTH-1:0]         m_eth_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_eth_payload_axis_tkeep,
   output logic                          m_eth_payload_axis_tvalid,
   input  logic                          m_eth_payload_axis_tready,
   output logic                          m_eth_payload_axis_tlast,
   output logic                          m_eth_payload_axis_tuser,
   output logic                          m_grant_valid,
   output logic [$clog2(S_COUNT)-1:0]    m_grant_index
);

   localparam int IW = $clog2(S_COUNT);
   localparam int BW = DATA_WIDTH + KEEP_WIDTH + 2;

   arb_state_e         state_q, state_d;
   logic               grant_valid_q, grant_valid_d;
   logic [IW-1:0]      grant_idx_q, grant_idx_d;
   logic [S_COUNT-1:0] grant_oh_q, grant_oh_d;

   logic               w_arb_any;
   logic               w_arb_upd;
   logic [S_COUNT-1:0] w_arb_oh;
   logic [IW-1:0]      w_arb_idx;

   eth_rr_arbiter #(
      .N  (S_COUNT),
      .IW (IW)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (s_eth_hdr_valid),
      .upd_en_i    (w_arb_upd),
      .grant_any_o (w_arb_any),
      .grant_oh_o  (w_arb_oh),
      .grant_idx_o (w_arb_idx)
   );

   // Granted source view
   logic              w_sel_hdr_valid;
   logic [MAC_W-1:0]  w_sel_dmac;
   logic [MAC_W-1:0]  w_sel_smac;
   logic [TYPE_W-1:0] w_sel_type;
   logic              w_sel_tvalid;
   logic [BW-1:0]     w_sel_beat;

   assign w_sel_hdr_valid = s_eth_hdr_valid[grant_idx_q];
   assign w_sel_dmac      = s_eth_dest_mac[grant_idx_q*MAC_W +: MAC_W];
   assign w_sel_smac      = s_eth_src_mac[grant_idx_q*MAC_W +: MAC_W];
   assign w_sel_type      = s_eth_type[grant_idx_q*TYPE_W +: TYPE_W];
   assign w_sel_tvalid    = s_eth_payload_axis_tvalid[grant_idx_q];
   assign w_sel_beat      = {s_eth_payload_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH],
                             s_eth_payload_axis_tkeep[grant_idx_q*KEEP_WIDTH +: KEEP_WIDTH],
                             s_eth_payload_axis_tlast[grant_idx_q],
                             s_eth_payload_axis_tuser[grant_idx_q]};

   // Header output register
   logic              hdr_valid_q;
   logic [MAC_W-1:0]  hdr_dmac_q;
   logic [MAC_W-1:0]  hdr_smac_q;
   logic [TYPE_W-1:0] hdr_type_q;
   logic              w_hdr_room;
   logic              w_hdr_fire;

   assign w_hdr_room = ~hdr_valid_q | m_eth_hdr_ready;
   assign w_hdr_fire = (state_q == ST_HDR) & w_sel_hdr_valid & w_hdr_room;

   always_ff @(posedge clk) begin
      if (rst) begin
         hdr_valid_q <= 1'b0;
         hdr_dmac_q  <= '0;
         hdr_smac_q  <= '0;
         hdr_type_q  <= '0;
      end else if (w_hdr_fire) begin
         hdr_valid_q <= 1'b1;
         hdr_dmac_q  <= w_sel_dmac;
         hdr_smac_q  <= w_sel_smac;
         hdr_type_q  <= w_sel_type;
      end else if (m_eth_hdr_ready) begin
         hdr_valid_q <= 1'b0;
      end
   end

   // Payload skid buffer: output register plus one overflow entry
   logic          out_valid_q;
   logic [BW-1:0] out_beat_q;
   logic          skid_valid_q;
   logic [BW-1:0] skid_beat_q;
   logic          w_in_ready;
   logic          w_in_fire;
   logic          w_tlast_fire;
   logic          w_out_free;

   assign w_in_ready   = (state_q == ST_PAYLOAD) & ~skid_valid_q;
   assign w_in_fire    = w_in_ready & w_sel_tvalid;
   assign w_tlast_fire = w_in_fire & w_sel_beat[1];
   assign w_out_free   = ~out_valid_q | m_eth_payload_axis_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_beat_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_beat_q  <= '0;
      end else if (w_out_free) begin
         if (skid_valid_q) begin
            out_valid_q  <= 1'b1;
            out_beat_q   <= skid_beat_q;
            skid_valid_q <= 1'b0;
         end else begin
            out_valid_q <= w_in_fire;
            if (w_in_fire) begin
               out_beat_q <= w_sel_beat;
            end
         end
      end else if (w_in_fire) begin
         skid_valid_q <= 1'b1;
         skid_beat_q  <= w_sel_beat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         grant_oh_q    <= '0;
      end else begin
         state_q       <= state_d;
         grant_valid_q <= grant_valid_d;
         grant_idx_q   <= grant_idx_d;
         grant_oh_q    <= grant_oh_d;
      end
   end

   // The grant is frozen from IDLE until the granted tlast is accepted
   always_comb begin
      state_d       = state_q;
      grant_valid_d = grant_valid_q;
      grant_idx_d   = grant_idx_q;
      grant_oh_d    = grant_oh_q;
      w_arb_upd     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (w_arb_any) begin
               state_d       = ST_HDR;
               grant_valid_d = 1'b1;
               grant_idx_d   = w_arb_idx;
               grant_oh_d    = w_arb_oh;
               w_arb_upd     = 1'b1;
            end
         end
         ST_HDR: begin
            if (w_hdr_fire) begin
               state_d = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (w_tlast_fire) begin
               state_d       = ST_IDLE;
               grant_valid_d = 1'b0;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
         end
      endcase
   end

   assign s_eth_hdr_ready           = ((state_q == ST_HDR) && w_hdr_room) ? grant_oh_q : '0;
   assign s_eth_payload_axis_tready = w_in_ready ? grant_oh_q : '0;

   assign m_eth_hdr_valid = hdr_valid_q;
   assign m_eth_dest_mac  = hdr_dmac_q;
   assign m_eth_src_mac   = hdr_smac_q;
   assign m_eth_type      = hdr_type_q;

   assign m_eth_payload_axis_tvalid = out_valid_q;
   assign {m_eth_payload_axis_tdata, m_eth_payload_axis_tkeep,
           m_eth_payload_axis_tlast, m_eth_payload_axis_tuser} = out_beat_q;

   assign m_grant_valid = grant_valid_q;
   assign m_grant_index = grant_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_eth_frame_arb                                                |
// | Brief    : Randomized self-checking bench for eth_frame_arb.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_eth_frame_arb;

   localparam int S  = 4;
   localparam int DW = 16;
   localparam int KW = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [S-1:0]    s_eth_hdr_valid, s_eth_hdr_ready;
   logic [S*48-1:0] s_eth_dest_mac, s_eth_src_mac;
   logic [S*16-1:0] s_eth_type;
   logic [S*DW-1:0] s_tdata;
   logic [S*KW-1:0] s_tkeep;
   logic [S-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
   logic            m_eth_hdr_valid, m_eth_hdr_ready;
   logic [47:0]     m_eth_dest_mac, m_eth_src_mac;
   logic [15:0]     m_eth_type;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid, m_tready, m_tlast, m_tuser;
   logic            m_grant_valid;
   logic [1:0]      m_grant_index;

   eth_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .s_eth_hdr_valid           (s_eth_hdr_valid),
      .s_eth_hdr_ready           (s_eth_hdr_ready),
      .s_eth_dest_mac            (s_eth_dest_mac),
      .s_eth_src_mac             (s_eth_src_mac),
      .s_eth_type                (s_eth_type),
      .s_eth_payload_axis_tdata  (s_tdata),
      .s_eth_payload_axis_tkeep  (s_tkeep),
      .s_eth_payload_axis_tvalid (s_tvalid),
      .s_eth_payload_axis_tready (s_tready),
      .s_eth_payload_axis_tlast  (s_tlast),
      .s_eth_payload_axis_tuser  (s_tuser),
      .m_eth_hdr_valid           (m_eth_hdr_valid),
      .m_eth_hdr_ready           (m_eth_hdr_ready),
      .m_eth_dest_mac            (m_eth_dest_mac),
      .m_eth_src_mac             (m_eth_src_mac),
      .m_eth_type                (m_eth_type),
      .m_eth_payload_axis_tdata  (m_tdata),
      .m_eth_payload_axis_tkeep  (m_tkeep),
      .m_eth_payload_axis_tvalid (m_tvalid),
      .m_eth_payload_axis_tready (m_tready),
      .m_eth_payload_axis_tlast  (m_tlast),
      .m_eth_payload_axis_tuser  (m_tuser),
      .m_grant_valid             (m_grant_valid),
      .m_grant_index             (m_grant_index)
   );

   typedef struct packed {
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [15:0] typ;
   } hdr_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic          user;
   } beat_t;

   hdr_t   src_hdr_q[S][$];
   beat_t  src_beat_q[S][$];
   logic   hdr_sent[S];
   int     hold_hdr[S];
   hdr_t   exp_hdr_q[$];
   beat_t  exp_beat_q[$];
   int     exp_cyc_q[$];
   int     grant_log[$];

   int     n_total = 0;
   int     n_bad   = 0;
   int     cyc     = 0;

   // Transaction-level model of the arbiter
   bit     md_busy, md_pay;
   int     md_idx, md_ptr;

   bit     drop_en, gap_en, strict_lat;
   int     hrdy_mode, trdy_mode;
   bit     prev_stall, prev_hv, exp_hv;
   hdr_t   prev_hdr;
   int     t_arb, t_mhv, out_cnt, last_len, src2_fires, early_tv;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [S-1:0] req, input int ptr);
      for (int k = 0; k < S; k++) begin
         if (req[(ptr + k) % S]) return (ptr + k) % S;
      end
      return 0;
   endfunction

   // Pre-edge sampling: checks against the model, then advances it
   task automatic sample();
      logic [S-1:0] hf, pf, hmask, pmask;
      bit           lf;
      beat_t        b;
      hdr_t         h;
      int           c;
      hmask = (md_busy && !md_pay) ? 4'(1 << md_idx) : 4'b0;
      pmask = (md_busy && md_pay)  ? 4'(1 << md_idx) : 4'b0;
      chk("hdr_ready_mask", s_eth_hdr_ready & ~hmask, 0);
      chk("tready_mask", s_tready & ~pmask, 0);
      chk("grant_valid", m_grant_valid, md_busy);
      if (md_busy) chk("grant_index", m_grant_index, md_idx);
      if (s_tvalid[2] && !(md_busy && md_pay && md_idx == 2)) early_tv++;

      if (exp_hv) chk("hdr_valid_after_capture", m_eth_hdr_valid, 1);
      if (prev_stall) begin
         chk("hdr_hold_valid", m_eth_hdr_valid, 1);
         chk("hdr_hold_fields", {m_eth_dest_mac, m_eth_src_mac, m_eth_type} == prev_hdr, 1);
      end
      if (m_eth_hdr_valid && !prev_hv) t_mhv = cyc;
      prev_hv    = m_eth_hdr_valid;
      prev_stall = m_eth_hdr_valid && !m_eth_hdr_ready;
      prev_hdr   = {m_eth_dest_mac, m_eth_src_mac, m_eth_type};

      if (m_eth_hdr_valid && m_eth_hdr_ready) begin
         chk("hdr_expected", exp_hdr_q.size() > 0, 1);
         if (exp_hdr_q.size() > 0) begin
            h = exp_hdr_q.pop_front();
            chk("hdr_dmac", m_eth_dest_mac, h.dmac);
            chk("hdr_smac", m_eth_src_mac, h.smac);
            chk("hdr_type", m_eth_type, h.typ);
         end
      end
      if (m_tvalid && m_tready) begin
         chk("beat_expected", exp_beat_q.size() > 0, 1);
         if (exp_beat_q.size() > 0) begin
            b = exp_beat_q.pop_front();
            c = exp_cyc_q.pop_front();
            chk("beat_data", m_tdata, b.data);
            chk("beat_keep", m_tkeep, b.keep);
            chk("beat_last", m_tlast, b.last);
            chk("beat_user", m_tuser, b.user);
            if (strict_lat) chk("beat_latency", cyc - c, 1);
         end
         out_cnt++;
         if (m_tlast) begin
            last_len = out_cnt;
            out_cnt  = 0;
         end
      end

      hf = s_eth_hdr_valid & s_eth_hdr_ready;
      pf = s_tvalid & s_tready;
      lf = 1'b0;
      exp_hv = 1'b0;
      for (int i = 0; i < S; i++) begin
         if (hf[i]) begin
            exp_hdr_q.push_back(src_hdr_q[i][0]);
            hdr_sent[i] = 1'b1;
            exp_hv = 1'b1;
         end
         if (pf[i]) begin
            b = src_beat_q[i].pop_front();
            exp_beat_q.push_back(b);
            exp_cyc_q.push_back(cyc);
            if (i == 2) src2_fires++;
            if (b.last) begin
               lf = 1'b1;
               void'(src_hdr_q[i].pop_front());
               hdr_sent[i] = 1'b0;
            end
         end
      end

      if (md_busy) begin
         if (!md_pay) begin
            if (hf[md_idx]) md_pay = 1'b1;
         end else if (pf[md_idx] && lf) begin
            md_busy = 1'b0;
         end
      end else if (s_eth_hdr_valid != '0) begin
`ifdef ETH_FRAME_ARB_ROUND_ROBIN_EN
         md_idx = pick(s_eth_hdr_valid, md_ptr);
         md_ptr = (md_idx + 1) % S;
`else
         md_idx = pick(s_eth_hdr_valid, 0);
`endif
         md_busy = 1'b1;
         md_pay  = 1'b0;
         t_arb   = cyc;
         grant_log.push_back(md_idx);
      end
      cyc++;
   endtask

   task automatic drive();
      hdr_t  h;
      beat_t b;
      for (int i = 0; i < S; i++) begin
         h = '0;
         b = '0;
         if (src_hdr_q[i].size() > 0) h = src_hdr_q[i][0];
         if (src_beat_q[i].size() > 0) b = src_beat_q[i][0];
         s_eth_hdr_valid[i] = (src_hdr_q[i].size() > 0) && !hdr_sent[i] && (hold_hdr[i] == 0) &&
                              (!drop_en || $urandom_range(3) != 0);
         if (hold_hdr[i] > 0) hold_hdr[i]--;
         s_eth_dest_mac[i*48 +: 48] = h.dmac;
         s_eth_src_mac[i*48 +: 48]  = h.smac;
         s_eth_type[i*16 +: 16]     = h.typ;
         s_tvalid[i]         = (src_beat_q[i].size() > 0) && (!gap_en || $urandom_range(2) != 0);
         s_tdata[i*DW +: DW] = b.data;
         s_tkeep[i*KW +: KW] = b.keep;
         s_tlast[i]          = b.last;
         s_tuser[i]          = b.user;
      end
      m_eth_hdr_ready = (hrdy_mode == 0) ? 1'b1 : 1'($urandom_range(1));
      case (trdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ((cyc % 2) == 0);
         default: m_tready = 1'($urandom_range(1));
      endcase
   endtask

   task automatic step();
      #7;
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   function automatic bit all_idle();
      for (int i = 0; i < S; i++) begin
         if (src_hdr_q[i].size() > 0 || src_beat_q[i].size() > 0) return 1'b0;
      end
      return !md_busy && exp_hdr_q.size() == 0 && exp_beat_q.size() == 0 && !m_eth_hdr_valid;
   endfunction

   task automatic run_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!all_idle() && n < budget) begin
         step();
         n++;
      end
      chk(tag, n < budget, 1);
   endtask

   task automatic add_frame(input int s, input int len);
      hdr_t  h;
      beat_t b;
      h.dmac = {16'(16'hA000 + s), $urandom()};
      h.smac = {16'(16'h5000 + s), $urandom()};
      h.typ  = 16'($urandom());
      src_hdr_q[s].push_back(h);
      for (int k = 0; k < len; k++) begin
         b.data = DW'($urandom());
         b.keep = KW'($urandom());
         b.user = 1'($urandom());
         b.last = (k == len - 1);
         src_beat_q[s].push_back(b);
      end
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      for (int i = 0; i < S; i++) begin
         src_hdr_q[i].delete();
         src_beat_q[i].delete();
         hdr_sent[i] = 1'b0;
         hold_hdr[i] = 0;
      end
      drive();
      repeat (ncyc) @(posedge clk);
      #1;
      chk("rst_hdr_valid", m_eth_hdr_valid, 0);
      chk("rst_hdr_fields", {m_eth_dest_mac, m_eth_src_mac, m_eth_type} != '0, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tbeat", {m_tdata, m_tkeep, m_tlast, m_tuser}, 0);
      chk("rst_grant_valid", m_grant_valid, 0);
      chk("rst_grant_index", m_grant_index, 0);
      chk("rst_hdr_ready", s_eth_hdr_ready, 0);
      chk("rst_tready", s_tready, 0);
      rst = 1'b0;
      md_busy = 1'b0;
      md_pay  = 1'b0;
      md_ptr  = 0;
      md_idx  = 0;
      exp_hdr_q.delete();
      exp_beat_q.delete();
      exp_cyc_q.delete();
      prev_stall = 1'b0;
      prev_hv    = 1'b0;
      exp_hv     = 1'b0;
      out_cnt    = 0;
   endtask

   initial begin
      int n;
      s_eth_hdr_valid = '0; s_eth_dest_mac = '0; s_eth_src_mac = '0; s_eth_type = '0;
      s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
      m_eth_hdr_ready = 1'b1; m_tready = 1'b1;
      drop_en = 0; gap_en = 0; strict_lat = 0; hrdy_mode = 0; trdy_mode = 0;
      t_arb = 0; t_mhv = 0; last_len = 0; src2_fires = 0; early_tv = 0;
      @(posedge clk);
      #1;
      do_reset(3);

      // Single source 0, 3 beats
      strict_lat = 1;
      add_frame(0, 3);
      run_done("t1_timeout", 200);
      chk("t1_hdr_latency", t_mhv - t_arb, 2);
      chk("t1_frame_len", last_len, 3);

      // Sources 1 and 3 requesting together
      grant_log.delete();
      for (int f = 0; f < 3; f++) add_frame(1, 2);
      for (int f = 0; f < 2; f++) add_frame(3, 2);
      run_done("t2_timeout", 400);
      chk("t2_num_grants", grant_log.size(), 5);
`ifdef ETH_FRAME_ARB_ROUND_ROBIN_EN
      chk("t2_grant0", grant_log[0], 1);
      chk("t2_grant1", grant_log[1], 3);
      chk("t2_grant2", grant_log[2], 1);
      chk("t2_grant3", grant_log[3], 3);
`else
      chk("t2_grant0", grant_log[0], 1);
      chk("t2_grant1", grant_log[1], 1);
      chk("t2_grant2", grant_log[2], 1);
`endif

      // 16-beat frame under 1010 output ready
      strict_lat = 0;
      trdy_mode  = 1;
      add_frame(0, 16);
      run_done("t3_timeout", 300);
      chk("t3_frame_len", last_len, 16);
      trdy_mode  = 0;

      // Source 2 offers payload before its header
      strict_lat  = 1;
      early_tv    = 0;
      hold_hdr[2] = 6;
      add_frame(2, 4);
      run_done("t4_timeout", 200);
      chk("t4_early_tvalid_seen", early_tv > 3, 1);

      // Reset on beat 5 of 10, then new arbitration starts from pointer 0
      src2_fires = 0;
      add_frame(2, 10);
      n = 0;
      while (src2_fires < 5 && n < 100) begin
         step();
         n++;
      end
      chk("t5_reach_beat5", src2_fires, 5);
      do_reset(1);
      grant_log.delete();
      add_frame(1, 2);
      add_frame(3, 2);
      run_done("t5_timeout", 200);
      chk("t5_grant_after_reset", grant_log[0], 1);

      // Random traffic on all sources
      strict_lat = 0;
      drop_en    = 1;
      gap_en     = 1;
      hrdy_mode  = 1;
      trdy_mode  = 2;
      for (int s = 0; s < S; s++) begin
         for (int f = 0; f < 3; f++) add_frame(s, $urandom_range(6, 1));
      end
      run_done("t6_timeout", 4000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/eth_frame_arb.md
ETH_FRAME_ARB -- requirements
Module: eth_frame_arb

Interface
REQ-001 SHALL have parameter S_COUNT, default 4: number of Ethernet frame sources, legal range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: payload data width, a multiple of 8.
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8: payload tkeep width.
REQ-004 SHALL have port clk, in, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-006 SHALL have port s_eth_hdr_valid, in, S_COUNT: header valid per source.
REQ-007 SHALL have port s_eth_hdr_ready, out, S_COUNT: header ready per source.
REQ-008 SHALL have port s_eth_{dest_mac,src_mac,type}, in, S_COUNT*{48,48,16}: packed header fields, with source i at slice i.
REQ-009 SHALL have port s_eth_payload_axis_{tdata,tkeep,tvalid,tlast,tuser}, in, S_COUNT*{DATA_WIDTH,KEEP_WIDTH,1,1,1}: packed payload streams.
REQ-010 SHALL have port s_eth_payload_axis_tready, out, S_COUNT: payload ready per source.
REQ-011 SHALL have port m_eth_hdr_valid, out, 1, and port m_eth_hdr_ready, in, 1: merged header handshake.
REQ-012 SHALL have port m_eth_{dest_mac,src_mac,type}, out, {48,48,16}: merged header fields.
REQ-013 SHALL have port m_eth_payload_axis_{tdata,tkeep,tvalid,tlast,tuser}, out, {DATA_WIDTH,KEEP_WIDTH,1,1,1}: merged payload stream.
REQ-014 SHALL have port m_eth_payload_axis_tready, in, 1: merged payload ready.
REQ-015 SHALL have ports m_grant_valid, out, 1, and m_grant_index, out, $clog2(S_COUNT): current grant status.

Function
REQ-016 SHALL implement an FSM with states IDLE, HDR and PAYLOAD: IDLE->HDR on a registered grant when any s_eth_hdr_valid is high; HDR->PAYLOAD on the granted source's header handshake; PAYLOAD->IDLE on the granted source's payload handshake with tlast=1.
REQ-017 SHALL register the grant: a request in cycle N with the FSM in IDLE gives m_grant_valid=1 with the winning index in cycle N+1.
REQ-018 SHALL assert s_eth_hdr_ready only at [m_grant_index], only in HDR, and only while the output header register is empty or being accepted; every other bit SHALL be 0.
REQ-019 SHALL capture the accepted header into the output header register; m_eth_hdr_valid SHALL rise the following cycle and SHALL hold with stable fields until m_eth_hdr_ready=1.
REQ-020 SHALL assert s_eth_payload_axis_tready only at [m_grant_index] and only in PAYLOAD, so no payload beat is accepted before its header.
REQ-021 SHALL forward payload through a 2-entry skid buffer with 1-cycle latency, passing tdata, tkeep, tlast and tuser unmodified, and sustaining full throughput under continuous m_eth_payload_axis_tready.
REQ-022 SHALL deassert m_grant_valid on the edge that accepts the granted tlast beat; the next grant SHALL come no earlier than one cycle later (one idle cycle between frames).
REQ-023 SHALL accept one header per grant; a payload of at least one beat is required, and zero-length frames are unsupported.
REQ-024 SHALL not change the grant while a frame is in progress, even if another source requests or the granted source drops s_eth_hdr_valid before its handshake (the grant then waits).

Reset
REQ-025 SHALL, on rst, force the FSM to IDLE, clear the skid buffer and header register, and drive all s_*_ready, m_*_valid, m_grant_valid and m_grant_index to 0.
REQ-026 SHALL, on rst mid-frame, abandon the frame with no synthesized tlast; the round-robin pointer SHALL return to 0.

Configuration
REQ-027 SHALL use macro ETH_FRAME_ARB_ROUND_ROBIN_EN: when defined, round-robin with the priority pointer moving to (granted index + 1) mod S_COUNT after each grant; when undefined, fixed priority with the lowest index winning.

Structure
REQ-028 SHALL place the FSM state enum and the header field width constants (MAC_W=48, TYPE_W=16) in shared package eth_pkg.
REQ-029 SHALL implement arbitration in sub-module eth_rr_arbiter (request vector in, one-hot/index grant out, with a pointer update enable).

Verification
REQ-030 SHALL cover: single source 0, header plus 3-beat payload -> m_eth_hdr_valid at cycle 2 and payload out with 1-cycle latency, tlast on beat 3.
REQ-031 SHALL cover: sources 1 and 3 requesting together with ROUND_ROBIN_EN defined -> grant order 1,3,1,3; with it undefined -> 1,1,1.
REQ-032 SHALL cover: m_eth_payload_axis_tready toggling 1010 during a 16-beat frame -> no lost or duplicated beats and tkeep/tuser intact.
REQ-033 SHALL cover: source 2 tvalid asserted before its header handshake -> s_eth_payload_axis_tready[2]=0 until PAYLOAD.
REQ-034 SHALL cover: rst asserted on beat 5 of 10 -> all outputs 0 the next cycle, and a new frame after reset is granted from pointer 0.
